// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Write-side front end for the 32x32 register file. Merges two writeback
//   producers onto the single regfile write port:
//     - ALU results (single cycle, highest priority)
//     - load returns (variable latency, buffered in a DEPTH-entry FIFO)
//   Writes to x0 are consumed and dropped. Per-register pending flags let
//   decode stall on RAW hazards until the value has landed in the regfile.
//
// Ports
//   clk, reset              clock / synchronous active-high reset
//   alu_valid/ready/rd/data ALU result handshake
//   ld_valid/ready/rd/data  load-return handshake
//   rd, we, wdata           registered regfile write port
//   q_rs1, q_rs2            hazard query addresses
//   pend_rs1, pend_rs2      a write to the queried register is in flight
//   fifo_count              load FIFO occupancy (0..DEPTH)

// One FIFO slot's hazard comparator: flags a match against either query
// address, but only while the slot holds a live entry.
module regfile_wb_slot_match #(
  parameter int AW = 5
) (
  input  logic          occ,
  input  logic [AW-1:0] slot_rd,
  input  logic [AW-1:0] q_rs1,
  input  logic [AW-1:0] q_rs2,
  output logic          hit1,
  output logic          hit2
);
  assign hit1 = occ && (slot_rd == q_rs1);
  assign hit2 = occ && (slot_rd == q_rs2);
endmodule

module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [AW-1:0]            alu_rd,
  input  logic [DW-1:0]            alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [AW-1:0]            ld_rd,
  input  logic [DW-1:0]            ld_data,
  output logic [AW-1:0]            rd,
  output logic                     we,
  output logic [DW-1:0]            wdata,
  input  logic [AW-1:0]            q_rs1,
  input  logic [AW-1:0]            q_rs2,
  output logic                     pend_rs1,
  output logic                     pend_rs2,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_t;

  wb_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic            we_q, we_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic            alu_wr, ld_push, fifo_pop;
  logic [DEPTH-1:0] occ, hit1, hit2;

  // Both producers see the same back-pressure: once the FIFO is full the
  // ALU is held off too, guaranteeing the next edge pops a load.
  assign alu_ready  = !reset && (count_q < FULL);
  assign ld_ready   = !reset && (count_q < FULL);

  assign rd         = rd_q;
  assign we         = we_q;
  assign wdata      = wdata_q;
  assign fifo_count = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rd_d     = rd_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;

    // x0 traffic still completes its handshake but never reaches the port.
    alu_wr   = alu_valid && alu_ready && (alu_rd != '0);
    ld_push  = ld_valid && ld_ready && (ld_rd != '0);
    // An ALU write owns the port this cycle; otherwise drain the FIFO head.
    fifo_pop = !alu_wr && (count_q != '0);

    if (alu_wr) begin
      rd_d    = alu_rd;
      wdata_d = alu_data;
      we_d    = 1'b1;
    end else if (fifo_pop) begin
      rd_d     = mem_q[rd_ptr_q].rd;
      wdata_d  = mem_q[rd_ptr_q].data;
      we_d     = 1'b1;
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // Push lands in the tail slot; no bypass to the output this cycle.
    if (ld_push) begin
      mem_d[wr_ptr_q] = '{rd: ld_rd, data: ld_data};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    count_d = count_q + CW'(ld_push) - CW'(fifo_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
    end
  end

  // Slot contents need no reset: occupancy gates every use of them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // A slot is live when its distance from the head is below the count,
  // so stale data left behind by pops never raises a hazard.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] off;
      off    = PW'(i) - rd_ptr_q;
      occ[i] = ({1'b0, off} < count_q);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    regfile_wb_slot_match #(.AW(AW)) u_match (
      .occ     (occ[g]),
      .slot_rd (mem_q[g].rd),
      .q_rs1   (q_rs1),
      .q_rs2   (q_rs2),
      .hit1    (hit1[g]),
      .hit2    (hit2[g])
    );
  end

  // The staged output write counts as in flight until the regfile takes it.
  assign pend_rs1 = (q_rs1 != '0) && ((we_q && (rd_q == q_rs1)) || (|hit1));
  assign pend_rs2 = (q_rs2 != '0) && ((we_q && (rd_q == q_rs2)) || (|hit2));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int BW    = 1 + AW + DW + CW;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, ld_valid;
  logic          alu_ready, ld_ready;
  logic [AW-1:0] alu_rd, ld_rd, rd, q_rs1, q_rs2;
  logic [DW-1:0] alu_data, ld_data, wdata;
  logic          we, pend_rs1, pend_rs2;
  logic [CW-1:0] fifo_count;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .rd(rd), .we(we), .wdata(wdata),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .pend_rs1(pend_rs1), .pend_rs2(pend_rs2),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Reference model: queue of pending loads plus the staged write.
  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq[$];
  logic          m_we;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_wd;

  function automatic logic m_ready();
    return !reset && (mq.size() < DEPTH);
  endfunction

  function automatic logic m_pend(logic [AW-1:0] q);
    if (q == 0) return 1'b0;
    if (m_we && m_rd == q) return 1'b1;
    foreach (mq[i]) if (mq[i].rd == q) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [BW-1:0] m_bundle();
    return {m_we, m_rd, m_wd, CW'(mq.size())};
  endfunction

  wire [BW-1:0] d_bundle = {we, rd, wdata, fifo_count};

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    ent_t e;
    logic rdy;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_we = 1'b0; m_rd = '0; m_wd = '0;
    end else begin
      rdy = mq.size() < DEPTH;
      if (alu_valid && rdy && alu_rd != 0) begin
        m_we = 1'b1; m_rd = alu_rd; m_wd = alu_data;
      end else if (mq.size() != 0) begin
        e = mq.pop_front();
        m_we = 1'b1; m_rd = e.rd; m_wd = e.data;
      end else begin
        m_we = 1'b0;
      end
      if (ld_valid && rdy && ld_rd != 0) begin
        e.rd = ld_rd; e.data = ld_data;
        mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1234_5678;
    ld_valid  = 1'b1; ld_rd  = 5'd4; ld_data  = 32'h8765_4321;
    q_rs1 = 5'd3; q_rs2 = 5'd4;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (alu_ready !== 1'b0 || ld_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready cyc%0d: alu_ready=%b ld_ready=%b, want 0 0", c, alu_ready, ld_ready);
      end
      tick();
      checks++;
      if (d_bundle !== {BW{1'b0}}) begin
        errors++;
        $display("FAIL reset_state cyc%0d: got %h want 0", c, d_bundle);
      end
    end
  endtask

  task automatic test_alu();
    reset = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0;
    tick();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF; q_rs1 = 5'd5;
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++; $display("FAIL alu_ready: got %b want 1", alu_ready);
    end
    tick();
    alu_valid = 1'b0;
    #1;
    checks++;
    if (d_bundle !== {1'b1, 5'd5, 32'hDEAD_BEEF, CW'(0)} || d_bundle !== m_bundle()) begin
      errors++; $display("FAIL alu_write: got %h want %h", d_bundle, m_bundle());
    end
    checks++;
    if (pend_rs1 !== 1'b1) begin
      errors++; $display("FAIL alu_pend_n1: got %b want 1", pend_rs1);
    end
    tick();
    checks++;
    if (we !== 1'b0 || pend_rs1 !== 1'b0) begin
      errors++; $display("FAIL alu_after: we=%b pend=%b want 0 0", we, pend_rs1);
    end
  endtask

  task automatic test_burst();
    alu_valid = 1'b1; alu_rd = 5'd9;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_rd = AW'(i + 1); ld_data = 32'h11 * (i + 1);
      alu_data = $urandom;
      #1;
      checks++;
      if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin
        errors++; $display("FAIL burst_ready%0d: ld=%b alu=%b want 1 1", i, ld_ready, alu_ready);
      end
      tick();
      checks++;
      if (d_bundle !== m_bundle() || rd !== 5'd9) begin
        errors++; $display("FAIL burst_alu%0d: got %h want %h", i, d_bundle, m_bundle());
      end
    end
    ld_valid = 1'b0;
    #1;
    checks++;
    if (fifo_count !== CW'(4) || alu_ready !== 1'b0 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL burst_full: count=%0d alu_ready=%b ld_ready=%b want 4 0 0", fifo_count, alu_ready, ld_ready);
    end
    tick();
    checks++;
    if (d_bundle !== {1'b1, 5'd1, 32'h11, CW'(3)} || d_bundle !== m_bundle()) begin
      errors++; $display("FAIL burst_pop1: got %h want %h", d_bundle, m_bundle());
    end
    alu_valid = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      tick();
      checks++;
      if (d_bundle !== {1'b1, AW'(k), 32'h11 * k, CW'(4 - k)} || d_bundle !== m_bundle()) begin
        errors++; $display("FAIL burst_pop%0d: got %h want %h", k, d_bundle, m_bundle());
      end
    end
    tick();
    checks++;
    if (we !== 1'b0) begin
      errors++; $display("FAIL burst_idle: we=%b want 0", we);
    end
  endtask

  task automatic test_x0();
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (ld_ready !== 1'b1) begin
      errors++; $display("FAIL x0_ld_ready: got %b want 1", ld_ready);
    end
    tick();
    ld_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hCAFE_F00D;
    #1;
    checks++;
    if (we !== 1'b0 || fifo_count !== CW'(0) || alu_ready !== 1'b1) begin
      errors++; $display("FAIL x0_ld: we=%b count=%0d alu_ready=%b want 0 0 1", we, fifo_count, alu_ready);
    end
    tick();
    alu_valid = 1'b0; q_rs1 = 5'd0;
    #1;
    checks++;
    if (we !== 1'b0 || fifo_count !== CW'(0) || pend_rs1 !== 1'b0) begin
      errors++; $display("FAIL x0_alu: we=%b count=%0d pend=%b want 0 0 0", we, fifo_count, pend_rs1);
    end
  endtask

  task automatic test_wrap();
    alu_valid = 1'b1; alu_rd = 5'd9;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_rd = AW'($urandom_range(1, 31)); ld_data = $urandom;
      tick();
    end
    alu_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ld_rd = AW'($urandom_range(1, 31)); ld_data = $urandom;
      q_rs1 = ld_rd;
      tick();
      checks++;
      if (d_bundle !== m_bundle() || fifo_count !== CW'(2) || pend_rs1 !== 1'b1) begin
        errors++;
        $display("FAIL wrap%0d: got %h want %h pend=%b", i, d_bundle, m_bundle(), pend_rs1);
      end
    end
    ld_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (d_bundle !== m_bundle()) begin
        errors++; $display("FAIL wrap_drain%0d: got %h want %h", i, d_bundle, m_bundle());
      end
    end
  endtask

  task automatic test_reset_mid();
    alu_valid = 1'b1; alu_rd = 5'd9;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_rd = AW'(20 + i); ld_data = 32'hA000_0000 + i;
      tick();
    end
    alu_valid = 1'b0; ld_valid = 1'b0; reset = 1'b1;
    tick();
    checks++;
    if (fifo_count !== CW'(0) || we !== 1'b0) begin
      errors++; $display("FAIL rstmid: count=%0d we=%b want 0 0", fifo_count, we);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (we !== 1'b0 || d_bundle !== m_bundle()) begin
        errors++; $display("FAIL rstmid_after%0d: got %h want %h", i, d_bundle, m_bundle());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 59) == 0);
      alu_valid = $urandom_range(0, 1);
      alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(0, 3) != 0);
      ld_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
      ld_data   = $urandom;
      q_rs1     = AW'($urandom_range(0, 31));
      q_rs2     = (mq.size() != 0) ? mq[0].rd : AW'($urandom_range(0, 31));
      #1;
      checks++;
      if (alu_ready !== m_ready() || ld_ready !== m_ready() ||
          pend_rs1 !== m_pend(q_rs1) || pend_rs2 !== m_pend(q_rs2)) begin
        errors++;
        $display("FAIL rnd_comb%0d: rdy=%b/%b pend=%b/%b want rdy=%b pend=%b/%b", c,
                 alu_ready, ld_ready, pend_rs1, pend_rs2, m_ready(), m_pend(q_rs1), m_pend(q_rs2));
      end
      tick();
      checks++;
      if (d_bundle !== m_bundle()) begin
        errors++; $display("FAIL rnd_out%0d: got %h want %h", c, d_bundle, m_bundle());
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    m_we = 1'b0; m_rd = '0; m_wd = '0;
    test_reset();
    test_alu();
    test_burst();
    test_x0();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
